cdb_arbiter: RTL

Collects completed results from the functional units. Buffers them per FU and broadcasts up to SS results per cycle on the common data bus (CDB). The CDB ROB tags drive the reservation station wakeup input, the ROB completion marking and the physical regfile writes. Fair round-robin selection across FUs; per-FU backpressure via ready.

---
 rtl/rv32i_types.sv | 13 +
 rtl/fu_result_fifo.sv | 50 +++++
 rtl/cdb_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared result-bus types: one CDB entry carries the ROB tag, destination preg, write flag and data.
package rv32i_types;
  localparam int ROB_DEPTH = 8;
  localparam int PREG_W    = 6;
  localparam int ROB_W     = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [ROB_W-1:0]  rob_idx;
    logic [PREG_W-1:0] pd;
    logic              rd_we;
    logic [31:0]       data;
  } cdb_entry_t;
endpackage

// File: rtl/fu_result_fifo.sv
// Per-FU circular result buffer; pushed entry is visible at head the cycle after the push edge.
// Pushes when full and pops when empty are dropped; rst/flush empty it synchronously.
module fu_result_fifo
  import rv32i_types::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  cdb_entry_t       push_data,
  input  logic             pop,
  output cdb_entry_t       head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  cdb_entry_t       mem [FIFO_DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[head_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[tail_ptr] <= push_data;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Buffers FU results per source and broadcasts up to SS of them per cycle, round-robin from rr_ptr.
// Results are eligible one cycle after acceptance; fu_ready drops only when that FU's buffer is full.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU     = 4,
  parameter int SS         = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  cdb_entry_t [NUM_FU-1:0] fu_result,
  output logic [NUM_FU-1:0]       fu_ready,
  output logic [SS-1:0]           cdb_valid,
  output cdb_entry_t [SS-1:0]     cdb_out
);
  localparam int RR_W  = $clog2(NUM_FU);
  localparam int SEL_W = $clog2(SS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_FU-1:0] fifo_empty;
  logic [CNT_W-1:0]  fifo_count [NUM_FU];
  cdb_entry_t        fifo_head  [NUM_FU];
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   last_idx;
  logic [SEL_W-1:0]  nsel;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign fu_ready[i] = (fifo_count[i] != CNT_W'(FIFO_DEPTH)) && !rst;

    fu_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (fu_valid[i] && fu_ready[i]),
      .push_data(fu_result[i]),
      .pop      (grant[i]),
      .head     (fifo_head[i]),
      .empty    (fifo_empty[i]),
      .count    (fifo_count[i])
    );
  end

  // Masking requests under flush keeps both the bus quiet and rr_ptr unchanged.
  assign req = ~fifo_empty & {NUM_FU{!(rst || flush)}};

  always_comb begin
    grant     = '0;
    cdb_valid = '0;
    cdb_out   = '0;
    last_idx  = rr_ptr;
    nsel      = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (((int'(rr_ptr) + off) % NUM_FU) == i && req[i] && nsel < SEL_W'(SS)) begin
          grant[i] = 1'b1;
          last_idx = RR_W'(i);
          for (int k = 0; k < SS; k++) begin
            if (nsel == SEL_W'(k)) begin
              cdb_valid[k] = 1'b1;
              cdb_out[k]   = fifo_head[i];
            end
          end
          nsel = nsel + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= '0;
    else if (|grant) rr_ptr <= (last_idx == RR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
  end
endmodule
